// File: rtl/mlp_pkg.sv
// Shared types and fixed-point helpers for the MLP datapath blocks.
// Q1.7 operands multiply into Q2.14 products; results saturate to 16-bit Q2.14.
package mlp_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    localparam int FRAC_IN  = 7;
    localparam int FRAC_ACC = 14;

    // Clamp a sign-extended wide sum into the signed 16-bit Q2.14 range.
    function automatic logic [15:0] sat_q2_14(input logic signed [31:0] v);
        logic [15:0] r;
        if (v > 32'sd32767)
            r = 16'h7FFF;
        else if (v < -32'sd32768)
            r = 16'h8000;
        else
            r = v[15:0];
        return r;
    endfunction

endpackage

// File: rtl/fxp_mult.sv
// Registered signed IN_BIT x IN_BIT multiplier with valid/last pass-through.
// Latency: 1 cycle from in_valid to p_valid.
// Backpressure: none; the caller only asserts in_valid when the stage after can absorb it.
module fxp_mult
    import mlp_pkg::*;
#(
    parameter int IN_BIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic signed [IN_BIT-1:0]   a,
    input  logic signed [IN_BIT-1:0]   b,
    output logic signed [2*IN_BIT-1:0] p,
    output logic                       p_valid,
    output logic                       p_last
);

    localparam int PW = 2 * IN_BIT;

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;

    assign a_ext = PW'(a);
    assign b_ext = PW'(b);

    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_valid <= in_valid;
            p_last  <= in_valid && in_last;
            if (in_valid)
                p <= a_ext * b_ext;
        end
    end

endmodule

// File: rtl/mac_neuron.sv
// Multiply-accumulate neuron: NUM_INPUTS Q1.7 pairs summed onto a Q2.14 bias, saturated, optional ReLU.
// Latency: result valid 2 cycles after the last beat is accepted.
// Backpressure: in_ready drops from the last beat until the result is taken; out holds while !out_ready.
module mac_neuron
    import mlp_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IN_BIT     = 8,
    parameter int OUT_BIT    = 16,
    parameter bit RELU       = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OUT_BIT-1:0] bias,
    input  logic [IN_BIT-1:0]  x,
    input  logic [IN_BIT-1:0]  w,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [OUT_BIT-1:0] out,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int ACC_W = OUT_BIT + $clog2(NUM_INPUTS) + 1;
    localparam int PW    = 2 * IN_BIT;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_INPUTS - 1);

    state_t state, state_nxt;

    logic [CNT_W-1:0]         cnt;
    logic [OUT_BIT-1:0]       bias_q;
    logic signed [PW-1:0]     p;
    logic                     p_valid;
    logic                     p_last;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_base;
    logic signed [ACC_W-1:0]  p_ext;
    logic                     first_q;
    logic                     fin_pend;
    logic                     accept;
    logic                     beat_last;
    logic [OUT_BIT-1:0]       sat_val;
    logic [OUT_BIT-1:0]       res_val;

    assign in_ready  = !rst && (state == IDLE || state == ACCUM);
    assign accept    = in_valid && in_ready;
    assign beat_last = (cnt == CNT_LAST);

    fxp_mult #(.IN_BIT(IN_BIT)) u_mult (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .in_last  (beat_last),
        .a        (x),
        .b        (w),
        .p        (p),
        .p_valid  (p_valid),
        .p_last   (p_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            bias_q <= '0;
        end else if (accept) begin
            if (cnt == '0)
                bias_q <= bias;
            cnt <= beat_last ? '0 : cnt + CNT_W'(1);
        end
    end

    // The bias joins the sum together with the first product of each group.
    assign p_ext    = ACC_W'(p);
    assign acc_base = first_q ? ACC_W'($signed(bias_q)) : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            first_q  <= 1'b1;
            fin_pend <= 1'b0;
        end else begin
            fin_pend <= p_valid && p_last;
            if (p_valid) begin
                acc     <= acc_base + p_ext;
                first_q <= p_last;
            end
        end
    end

    assign sat_val = OUT_BIT'(sat_q2_14(32'(acc)));
    assign res_val = (RELU && sat_val[OUT_BIT-1]) ? '0 : sat_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (fin_pend) begin
            out       <= res_val;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = beat_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && beat_last) state_nxt = DRAIN;
            DRAIN:   if (fin_pend) state_nxt = HOLD;
            HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_neuron.sv
// Bench for mac_neuron: three instances (N=4 ReLU, N=4 signed, N=1 ReLU) checked
// against an integer-arithmetic reference of the neuron equation.
module tb_mac_neuron;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: N=4 RELU=1, index 1: N=4 RELU=0, index 2: N=1 RELU=1
    logic [2:0][15:0] bias_v;
    logic [2:0][7:0]  x_v;
    logic [2:0][7:0]  w_v;
    logic [2:0]       iv_v;
    logic [2:0]       ordy_v;
    logic [2:0]       ir_v;
    logic [2:0]       ov_v;
    logic [2:0][15:0] out_v;

    int n_cmp = 0;
    int n_err = 0;

    mac_neuron #(.NUM_INPUTS(4), .IN_BIT(8), .OUT_BIT(16), .RELU(1'b1)) u_r1 (
        .clk(clk), .rst(rst), .bias(bias_v[0]), .x(x_v[0]), .w(w_v[0]),
        .in_valid(iv_v[0]), .in_ready(ir_v[0]), .out(out_v[0]),
        .out_valid(ov_v[0]), .out_ready(ordy_v[0]));

    mac_neuron #(.NUM_INPUTS(4), .IN_BIT(8), .OUT_BIT(16), .RELU(1'b0)) u_r0 (
        .clk(clk), .rst(rst), .bias(bias_v[1]), .x(x_v[1]), .w(w_v[1]),
        .in_valid(iv_v[1]), .in_ready(ir_v[1]), .out(out_v[1]),
        .out_valid(ov_v[1]), .out_ready(ordy_v[1]));

    mac_neuron #(.NUM_INPUTS(1), .IN_BIT(8), .OUT_BIT(16), .RELU(1'b1)) u_n1 (
        .clk(clk), .rst(rst), .bias(bias_v[2]), .x(x_v[2]), .w(w_v[2]),
        .in_valid(iv_v[2]), .in_ready(ir_v[2]), .out(out_v[2]),
        .out_valid(ov_v[2]), .out_ready(ordy_v[2]));

    function automatic logic [15:0] ref_model(input logic [15:0] b, input logic [7:0] xs[4],
                                              input logic [7:0] ws[4], input int n, input bit relu);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < n; i++)
            s += int'($signed(xs[i])) * int'($signed(ws[i]));
        if (s > 32767)
            s = 32767;
        else if (s < -32768)
            s = -32768;
        if (relu && s < 0)
            s = 0;
        return 16'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int d);
        int g = 0;
        while (!ir_v[d] && g < 50) begin
            tick();
            g++;
        end
        chk("in_ready_wait", 32'(ir_v[d]), 32'd1);
    endtask

    // Later beats carry random bias to show only the first beat's bias is used.
    task automatic send_beats(input int d, input logic [15:0] b, input logic [7:0] xs[4],
                              input logic [7:0] ws[4], input int n);
        for (int i = 0; i < n; i++) begin
            x_v[d]    = xs[i];
            w_v[d]    = ws[i];
            bias_v[d] = (i == 0) ? b : 16'($urandom);
            iv_v[d]   = 1'b1;
            wait_rdy(d);
            tick();
        end
        iv_v[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, input string tag);
        int lat = 0;
        while (!ov_v[d] && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd2);
    endtask

    task automatic finish_out(input int d);
        ordy_v[d] = 1'b1;
        tick();
        ordy_v[d] = 1'b0;
        chk("out_valid_after_hs", 32'(ov_v[d]), 32'd0);
        chk("in_ready_after_hs", 32'(ir_v[d]), 32'd1);
    endtask

    task automatic run_group(input int d, input logic [15:0] b, input logic [7:0] xs[4],
                             input logic [7:0] ws[4], input int n, input logic [15:0] exp,
                             input string tag);
        send_beats(d, b, xs, ws, n);
        wait_out(d, tag);
        chk(tag, 32'(out_v[d]), 32'(exp));
        finish_out(d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_out"}, 32'(out_v[d]), 32'd0);
            chk({tag, "_out_valid"}, 32'(ov_v[d]), 32'd0);
            chk({tag, "_in_ready"}, 32'(ir_v[d]), 32'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  xs[4];
        logic [7:0]  ws[4];
        logic [15:0] b;
        logic [15:0] exp;
        bit          pat[7];
        int          j;
        int          d;

        rst    = 1'b1;
        bias_v = '0;
        x_v    = '0;
        w_v    = '0;
        iv_v   = '0;
        ordy_v = '0;
        tick();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk("in_ready_post_reset", 32'(ir_v[k]), 32'd1);

        xs = '{8'h40, 8'h40, 8'h40, 8'h40};
        ws = '{8'h40, 8'h40, 8'h40, 8'h40};
        run_group(0, 16'h0000, xs, ws, 4, 16'h4000, "half_sum");

        xs = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        ws = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        run_group(0, 16'h0000, xs, ws, 4, 16'h7FFF, "sat_pos");

        xs = '{8'h80, 8'h80, 8'h80, 8'h80};
        ws = '{8'h40, 8'h40, 8'h40, 8'h40};
        run_group(1, 16'h0000, xs, ws, 4, 16'h8000, "neg_exact");
        run_group(0, 16'h0000, xs, ws, 4, 16'h0000, "neg_relu");

        xs = '{8'h80, 8'h00, 8'h00, 8'h00};
        ws = '{8'h80, 8'h00, 8'h00, 8'h00};
        run_group(2, 16'hC000, xs, ws, 1, 16'h0000, "single_beat");

        // Backpressure: result must hold with in_ready low until accepted.
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'($urandom);
            ws[i] = 8'($urandom);
        end
        b   = 16'($urandom);
        exp = ref_model(b, xs, ws, 4, 1'b1);
        send_beats(0, b, xs, ws, 4);
        wait_out(0, "bp");
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_out_stable", 32'(out_v[0]), 32'(exp));
            chk("bp_valid_held", 32'(ov_v[0]), 32'd1);
            chk("bp_in_ready_low", 32'(ir_v[0]), 32'd0);
        end
        finish_out(0);

        // Gapped input: in_valid 1,0,0,1,0,1,1 carries exactly four beats.
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            xs[i] = 8'($urandom);
            ws[i] = 8'($urandom);
        end
        b   = 16'($urandom);
        exp = ref_model(b, xs, ws, 4, 1'b0);
        j   = 0;
        for (int i = 0; i < 7; i++) begin
            iv_v[1] = pat[i];
            if (pat[i]) begin
                x_v[1]    = xs[j];
                w_v[1]    = ws[j];
                bias_v[1] = (j == 0) ? b : 16'($urandom);
                j++;
            end else begin
                x_v[1]    = 8'($urandom);
                w_v[1]    = 8'($urandom);
                bias_v[1] = 16'($urandom);
            end
            tick();
        end
        iv_v[1] = 1'b0;
        wait_out(1, "gaps");
        chk("gaps_out", 32'(out_v[1]), 32'(exp));
        finish_out(1);

        for (int g = 0; g < 12; g++) begin
            d = $urandom_range(0, 2);
            for (int i = 0; i < 4; i++) begin
                xs[i] = 8'($urandom);
                ws[i] = 8'($urandom);
            end
            b   = 16'($urandom);
            exp = ref_model(b, xs, ws, (d == 2) ? 1 : 4, d != 1);
            run_group(d, b, xs, ws, (d == 2) ? 1 : 4, exp, "rand_out");
        end

        // Reset partway through a group discards the partial sum.
        xs = '{8'h7F, 8'h7F, 8'h40, 8'h40};
        ws = '{8'h7F, 8'h7F, 8'h40, 8'h40};
        send_beats(0, 16'h1234, xs, ws, 2);
        rst = 1'b1;
        tick();
        chk_reset_outputs("mid_reset");
        tick();
        chk_reset_outputs("mid_reset_hold");
        rst = 1'b0;
        #1;
        xs = '{8'h40, 8'h40, 8'h40, 8'h40};
        ws = '{8'h40, 8'h40, 8'h40, 8'h40};
        run_group(0, 16'h0000, xs, ws, 4, 16'h4000, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
